// File: rtl/flash_arbiter_pkg.sv
// Shared types and constants for the flash_arbiter block:
// FSM state encoding, lamp-bar levels and parameter defaults.
package flash_arbiter_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int MAX_RUN_DEF = 1_000_000;

  localparam logic [15:0] LAMPS_FULL = 16'hFFFF;
  localparam logic [15:0] LAMPS_OFF  = 16'h0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    RUN     = 2'd2,
    RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/flash_arbiter_rr_pick4.sv
// Combinational 4-way round-robin pick: first asserted request at or after ptr_i,
// wrapping modulo 4.
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [1:0] winner_o,
  output logic       any_o
);

  logic [1:0] idx;

  always_comb begin
    winner_o = ptr_i;
    any_o    = 1'b0;
    idx      = ptr_i;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_i + 2'(i);
      if (!any_o && req_i[idx]) begin
        winner_o = idx;
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flash_arbiter.sv
// Round-robin owner of a shared bound-flasher lamp bar: grants one requester a run,
// forwards its flick, and releases on lamp-bar completion or watchdog expiry.
module flash_arbiter
  import flash_arbiter_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int MAX_RUN = MAX_RUN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] flick_in,
  input  logic [15:0]      lamps,
  output logic             flick_out,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       owner,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  localparam logic [31:0] MAX_RUN_C = 32'(MAX_RUN);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]       owner_q, owner_d;
  logic             busy_q, busy_d;
  logic             flick_q, flick_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [15:0]      lamps_q;

  logic [1:0] winner;
  logic       any_req;
  logic       complete;

  rr_pick4 u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (winner),
    .any_o    (any_req)
  );

  assign complete = (lamps_q == LAMPS_FULL) && (lamps == LAMPS_OFF);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    flick_d   = flick_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (any_req) begin
          state_d        = START;
          gnt_d          = '0;
          gnt_d[winner]  = 1'b1;
          owner_d        = winner;
          busy_d         = 1'b1;
          flick_d        = 1'b1;
        end
      end
      START: begin
        state_d = RUN;
        cnt_d   = '0;
        flick_d = flick_in[owner_q];
      end
      RUN: begin
        cnt_d   = cnt_q + 32'd1;
        flick_d = flick_in[owner_q];
        // Completion is checked first so it wins a tie with the watchdog.
        if (complete) begin
          state_d = RELEASE;
          done_d  = 1'b1;
          gnt_d   = '0;
          busy_d  = 1'b0;
          flick_d = 1'b0;
        end else if (cnt_q + 32'd1 == MAX_RUN_C) begin
          state_d   = RELEASE;
          timeout_d = 1'b1;
          gnt_d     = '0;
          busy_d    = 1'b0;
          flick_d   = 1'b0;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        ptr_d   = owner_q + 2'd1;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      owner_q   <= '0;
      busy_q    <= 1'b0;
      flick_q   <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      lamps_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      flick_q   <= flick_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      lamps_q   <= lamps;
    end
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign flick_out = flick_q;
  assign done      = done_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter with a short watchdog (MAX_RUN=50).
module tb_flash_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  flick_in;
  logic [15:0] lamps;
  logic        flick_out;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic        done;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  flash_arbiter #(.N_REQ(4), .MAX_RUN(50)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .flick_in  (flick_in),
    .lamps     (lamps),
    .flick_out (flick_out),
    .gnt       (gnt),
    .owner     (owner),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives lamps FFFF then 0000 from the first RUN cycle; ends in the RELEASE cycle.
  task automatic finish_run();
    tick();
    lamps = 16'hFFFF;
    tick();
    lamps = 16'h0000;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; flick_in = '0; lamps = '0;
    tick(); tick();
    n_checks++;
    if ({gnt, owner, busy, flick_out, done, timeout} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b owner=%0d busy=%b flick=%b done=%b to=%b, want all 0",
               gnt, owner, busy, flick_out, done, timeout);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    n_checks++;
    if (gnt !== 4'b0001 || flick_out !== 1'b1 || busy !== 1'b1 || owner !== 2'd0) begin
      n_fail++;
      $display("FAIL single_start: got gnt=%b flick=%b busy=%b owner=%0d, want 0001 1 1 0",
               gnt, flick_out, busy, owner);
    end
    finish_run();
    n_checks++;
    if (done !== 1'b1 || gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: got done=%b gnt=%b busy=%b to=%b, want 1 0000 0 0",
               done, gnt, busy, timeout);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done_pulse: got done=%b, want 0", done);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111;
    tick();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (gnt !== exp_gnt[k] || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got gnt=%b busy=%b, want %b 1", k, gnt, busy, exp_gnt[k]);
      end
      if (k == 3) req = 4'b0000;
      finish_run();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b1 || gnt !== 4'b0000) begin
        n_fail++;
        $display("FAIL rr_release%0d: got busy=%b done=%b gnt=%b, want 0 1 0000", k, busy, done, gnt);
      end
      tick();
      tick();
    end
  endtask

  task automatic test_timeout();
    logic early_bad = 1'b0;
    lamps = 16'h003F;
    req = 4'b0100;
    tick();
    req = 4'b0000;
    n_checks++;
    if (gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL to_grant: got gnt=%b, want 0100", gnt);
    end
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (timeout !== 1'b0 || busy !== 1'b1 || done !== 1'b0) early_bad = 1'b1;
    end
    n_checks++;
    if (early_bad) begin
      n_fail++;
      $display("FAIL to_early: got an early release within 50 run cycles, want none");
    end
    tick();
    n_checks++;
    if (timeout !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL to_pulse: got to=%b done=%b busy=%b gnt=%b, want 1 0 0 0000",
               timeout, done, busy, gnt);
    end
    tick();
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL to_pulse_width: got to=%b, want 0", timeout);
    end
  endtask

  task automatic test_tie();
    lamps = 16'h0000;
    req = 4'b1000;
    tick();
    req = 4'b0000;
    n_checks++;
    if (gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL tie_grant: got gnt=%b, want 1000", gnt);
    end
    for (int i = 1; i <= 48; i++) tick();
    tick();
    lamps = 16'hFFFF;
    tick();
    lamps = 16'h0000;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_still_run: got busy=%b at run cycle 50, want 1", busy);
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_priority: got done=%b to=%b, want 1 0", done, timeout);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    req = 4'b0100;
    tick(); tick(); tick();
    n_checks++;
    if (owner !== 2'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_owner: got owner=%0d busy=%b, want 2 1", owner, busy);
    end
    req = 4'b0101;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({gnt, owner, busy, flick_out, done, timeout} !== 10'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: got gnt=%b owner=%0d busy=%b flick=%b, want all 0",
               gnt, owner, busy, flick_out);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (gnt !== 4'b0001 || owner !== 2'd0) begin
      n_fail++;
      $display("FAIL rstmid_first_grant: got gnt=%b owner=%0d, want 0001 0", gnt, owner);
    end
    req = 4'b0000;
    finish_run();
    tick();
  endtask

  task automatic test_flick();
    req = 4'b0010;
    flick_in = 4'b1101;
    tick();
    req = 4'b0000;
    n_checks++;
    if (owner !== 2'd1 || flick_out !== 1'b1) begin
      n_fail++;
      $display("FAIL flick_start: got owner=%0d flick=%b, want 1 1", owner, flick_out);
    end
    tick();
    n_checks++;
    if (flick_out !== 1'b0) begin
      n_fail++;
      $display("FAIL flick_non_owner: got flick=%b, want 0", flick_out);
    end
    flick_in = 4'b0010;
    n_checks++;
    if (flick_out !== 1'b0) begin
      n_fail++;
      $display("FAIL flick_registered: got flick=%b before edge, want 0", flick_out);
    end
    tick();
    n_checks++;
    if (flick_out !== 1'b1) begin
      n_fail++;
      $display("FAIL flick_owner: got flick=%b, want 1", flick_out);
    end
    lamps = 16'hFFFF;
    tick();
    lamps = 16'h0000;
    tick();
    n_checks++;
    if (done !== 1'b1 || flick_out !== 1'b0) begin
      n_fail++;
      $display("FAIL flick_release: got done=%b flick=%b, want 1 0", done, flick_out);
    end
    flick_in = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_tie();
    test_reset_mid_run();
    test_flick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
